// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: four-deep writeback scoreboard, SAD occupancy
// counter, load-use/RAW stall, redirect flush and a saturating stall counter.
module ex_hazard_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_regwrite,
    input  logic [4:0]  id_dst,
    input  logic [1:0]  id_memread,
    input  logic        id_sad,
    input  logic        ex4_redirect,
    output logic        stall,
    output logic        flush,
    output logic        sad_busy,
    output logic [15:0] stall_count
);

    // Index 0 is EX1, index 3 is EX4.
    logic [3:0]      sb_valid;
    logic [3:0][4:0] sb_dst;
    logic [3:0]      sb_load;
    logic [1:0]      sad_cnt;

    logic [3:0] elig;
    logic       raw_hz;
    logic       sad_hz;
    logic       rs_live;
    logic       rt_live;
    logic       new_valid;
    logic       sad_issue;

    // A non-load result in EX4 is forwarded, so only loads stall from there.
    assign elig    = sb_valid & {sb_load[3], 3'b111};
    assign rs_live = id_uses_rs & (id_rs != 5'd0);
    assign rt_live = id_uses_rt & (id_rt != 5'd0);

    always_comb begin
        raw_hz = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (elig[i]) begin
                if (rs_live && (id_rs == sb_dst[i]))
                    raw_hz = 1'b1;
                if (rt_live && (id_rt == sb_dst[i]))
                    raw_hz = 1'b1;
            end
        end
    end

    assign sad_hz    = id_valid & id_sad & (sad_cnt != 2'd0);
    assign flush     = ~Reset & ex4_redirect;
    assign stall     = ~Reset & id_valid & (raw_hz | sad_hz) & ~ex4_redirect;
    assign sad_busy  = ~Reset & (sad_cnt != 2'd0);
    assign new_valid = id_valid & id_regwrite & (id_dst != 5'd0) & ~stall;
    assign sad_issue = id_valid & id_sad & ~stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sb_valid    <= '0;
            sb_dst      <= '0;
            sb_load     <= '0;
            sad_cnt     <= 2'd0;
            stall_count <= 16'd0;
        end else begin
            if (stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
            if (flush) begin
                sb_valid <= '0;
                sad_cnt  <= 2'd0;
            end else begin
                sb_valid <= {sb_valid[2:0], new_valid};
                sb_dst   <= {sb_dst[2:0], id_dst};
                sb_load  <= {sb_load[2:0], (id_memread != 2'd0)};
                if (sad_issue)
                    sad_cnt <= 2'd3;
                else if (sad_cnt != 2'd0)
                    sad_cnt <= sad_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed vector table, random run against a
// cycle-level reference model, and a stall counter saturation run.
module tb_ex_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_regwrite;
    logic [4:0]  id_dst;
    logic [1:0]  id_memread;
    logic        id_sad;
    logic        ex4_redirect;
    logic        stall;
    logic        flush;
    logic        sad_busy;
    logic [15:0] stall_count;

    always #5 Clk = ~Clk;

    ex_hazard_ctrl dut (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_dst(id_dst),
        .id_memread(id_memread), .id_sad(id_sad),
        .ex4_redirect(ex4_redirect), .stall(stall), .flush(flush),
        .sad_busy(sad_busy), .stall_count(stall_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: list of in-flight writers, SAD busy window end cycle.
    typedef struct {
        bit       v;
        bit [4:0] dst;
        bit       ld;
    } ent_t;

    ent_t pipe [4];
    int   sad_end = -1;
    int   mcnt = 0;
    int   cyc = 0;

    function automatic bit m_busy();
        return !Reset && (sad_end >= cyc);
    endfunction

    function automatic bit m_flush();
        return !Reset && ex4_redirect;
    endfunction

    function automatic bit reads(input bit [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r);
    endfunction

    function automatic bit m_stall();
        bit hz = 1'b0;
        if (Reset || !id_valid || ex4_redirect) return 1'b0;
        for (int k = 0; k < 4; k++)
            if (pipe[k].v && reads(pipe[k].dst) && (k < 3 || pipe[k].ld))
                hz = 1'b1;
        if (id_sad && m_busy()) hz = 1'b1;
        return hz;
    endfunction

    task automatic model_edge(input bit st, input bit fl);
        if (Reset) begin
            for (int k = 0; k < 4; k++) pipe[k] = '{1'b0, 5'd0, 1'b0};
            sad_end = -1;
            mcnt = 0;
        end else begin
            if (st && mcnt < 65535) mcnt++;
            if (fl) begin
                for (int k = 0; k < 4; k++) pipe[k].v = 1'b0;
                sad_end = -1;
            end else begin
                for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0].v   = id_valid && id_regwrite && id_dst != 5'd0 && !st;
                pipe[0].dst = id_dst;
                pipe[0].ld  = id_memread != 2'd0;
                if (id_valid && id_sad && !st) sad_end = cyc + 3;
            end
        end
        cyc++;
    endtask

    // Inputs are driven at negedge; outputs sampled 2ns later.
    task automatic step(input bit mchk);
        bit st;
        bit fl;
        #2;
        st = m_stall();
        fl = m_flush();
        if (mchk) begin
            check("m_stall", {15'd0, stall}, {15'd0, st});
            check("m_flush", {15'd0, flush}, {15'd0, fl});
            check("m_busy", {15'd0, sad_busy}, {15'd0, m_busy()});
            check("m_count", stall_count, mcnt[15:0]);
        end
        @(posedge Clk);
        model_edge(st, fl);
        @(negedge Clk);
    endtask

    typedef struct {
        bit        rst, v;
        bit [4:0]  rs;
        bit        urs;
        bit [4:0]  rt;
        bit        urt, rw;
        bit [4:0]  dst;
        bit [1:0]  mr;
        bit        sad, rd;
        bit        es, ef, eb;
        bit [15:0] ec;
    } vec_t;

    vec_t tv [$];

    function automatic vec_t mk(
        input bit rst, v, input bit [4:0] rs, input bit urs,
        input bit [4:0] rt, input bit urt, rw, input bit [4:0] dst,
        input bit [1:0] mr, input bit sad, rd, es, ef, eb,
        input bit [15:0] ec);
        vec_t t;
        t = '{rst, v, rs, urs, rt, urt, rw, dst, mr, sad, rd, es, ef, eb, ec};
        return t;
    endfunction

    task automatic drive(input bit rst, v, input bit [4:0] rs, input bit urs,
                         input bit [4:0] rt, input bit urt, rw,
                         input bit [4:0] dst, input bit [1:0] mr,
                         input bit sad, rd);
        Reset = rst; id_valid = v; id_rs = rs; id_uses_rs = urs;
        id_rt = rt; id_uses_rt = urt; id_regwrite = rw; id_dst = dst;
        id_memread = mr; id_sad = sad; ex4_redirect = rd;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        step(0);
        step(0);

        // rst v rs urs rt urt rw dst mr sad rd | stall flush busy count
        tv.push_back(mk(1,1, 8,1, 0,0, 1, 8,1, 1,1, 0,0,0, 0));
        tv.push_back(mk(0,1, 0,0, 0,0, 1, 8,1, 0,0, 0,0,0, 0));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,0, 1,0,0, 0));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,0, 1,0,0, 1));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,0, 1,0,0, 2));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,0, 1,0,0, 3));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,0, 0,0,0, 4));
        tv.push_back(mk(0,1, 0,0, 0,0, 1, 9,0, 0,0, 0,0,0, 4));
        tv.push_back(mk(0,1, 0,0, 9,1, 0, 0,0, 0,0, 1,0,0, 4));
        tv.push_back(mk(0,1, 0,0, 9,1, 0, 0,0, 0,0, 1,0,0, 5));
        tv.push_back(mk(0,1, 0,0, 9,1, 0, 0,0, 0,0, 1,0,0, 6));
        tv.push_back(mk(0,1, 0,0, 9,1, 0, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 1,10,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1,10,1, 0,0, 0, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 1, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,1, 0,1, 0, 0,0, 0,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 1,0, 0,0,0, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 1,0, 1,0,1, 7));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 1,0, 1,0,1, 8));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 1,0, 1,0,1, 9));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 1,0, 0,0,0,10));
        tv.push_back(mk(0,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,1,10));
        tv.push_back(mk(0,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,1,10));
        tv.push_back(mk(0,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,1,10));
        tv.push_back(mk(0,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0,10));
        tv.push_back(mk(0,1, 0,0, 0,0, 1, 8,2, 0,0, 0,0,0,10));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0,10));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,1, 0,1,0,10));
        tv.push_back(mk(0,1, 8,1, 0,0, 0, 0,0, 0,0, 0,0,0,10));
        tv.push_back(mk(0,1, 0,0, 0,0, 0, 0,0, 1,0, 0,0,0,10));
        tv.push_back(mk(0,0, 0,0, 0,0, 0, 0,0, 0,1, 0,1,1,10));
        tv.push_back(mk(0,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0,10));
        tv.push_back(mk(0,1, 0,0, 0,0, 1, 5,1, 0,0, 0,0,0,10));
        tv.push_back(mk(0,1, 5,1, 0,0, 0, 0,0, 0,0, 1,0,0,10));
        tv.push_back(mk(1,1, 5,1, 0,0, 0, 0,0, 1,1, 0,0,0,11));
        tv.push_back(mk(0,1, 5,1, 0,0, 0, 0,0, 0,0, 0,0,0, 0));
        tv.push_back(mk(0,1, 0,0, 0,0, 1, 7,1, 1,0, 0,0,0, 0));
        tv.push_back(mk(0,1, 7,1, 0,0, 0, 0,0, 1,0, 1,0,1, 0));
        tv.push_back(mk(0,1, 7,1, 0,0, 0, 0,0, 1,0, 1,0,1, 1));
        tv.push_back(mk(0,1, 7,1, 0,0, 0, 0,0, 1,0, 1,0,1, 2));
        tv.push_back(mk(0,1, 7,1, 0,0, 0, 0,0, 1,0, 1,0,0, 3));
        tv.push_back(mk(0,1, 7,1, 0,0, 0, 0,0, 1,0, 0,0,0, 4));

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].v, tv[i].rs, tv[i].urs, tv[i].rt,
                  tv[i].urt, tv[i].rw, tv[i].dst, tv[i].mr, tv[i].sad,
                  tv[i].rd);
            #1;
            check($sformatf("v%0d_stall", i), {15'd0, stall}, {15'd0, tv[i].es});
            check($sformatf("v%0d_flush", i), {15'd0, flush}, {15'd0, tv[i].ef});
            check($sformatf("v%0d_busy", i), {15'd0, sad_busy}, {15'd0, tv[i].eb});
            check($sformatf("v%0d_count", i), stall_count, tv[i].ec);
            step(0);
        end

        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
            step(1);
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        // Self-dependent load: stalls four of every five cycles.
        drive(0, 1, 8, 1, 0, 0, 1, 8, 1, 0, 0);
        for (int n = 0; n < 82000; n++) step(0);
        #1;
        check("sat_count", stall_count, 16'hFFFF);
        check("sat_model", stall_count, mcnt[15:0]);
        step(0);
        check("sat_hold", stall_count, 16'hFFFF);
        drive(1, 1, 8, 1, 0, 0, 1, 8, 1, 0, 1);
        #1;
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_flush", {15'd0, flush}, 16'd0);
        step(0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_count", stall_count, 16'd0);
        check("rst_busy", {15'd0, sad_busy}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 Clk  in  1  rising-edge clock for all state.
REQ-002 Reset  in  1  reset; synchronous, active-high; clock Clk.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_rs, id_rt  in  5 each  ID source register addresses.
REQ-005 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source.
REQ-006 id_regwrite  in  1  ID instruction writes id_dst.
REQ-007 id_dst  in  5  ID destination register.
REQ-008 id_memread  in  2  nonzero = ID instruction is a load.
REQ-009 id_sad  in  1  ID instruction is the custom SAD instruction.
REQ-010 ex4_redirect  in  1  Jump or JR resolved in EX4 this cycle.
REQ-011 stall  out  1  hold PC and IF/ID; inject bubble into ID/EX1.
REQ-012 flush  out  1  clear IF/ID and the EX1/EX2, EX2/EX3 and EX3/EX4 registers at the next edge.
REQ-013 sad_busy  out  1  SAD unit occupied.
REQ-014 stall_count  out  16  saturating count of stall cycles since reset.

Function
REQ-015 Scoreboard SHALL hold four entries (EX1..EX4); each entry = {valid, dst[4:0], load}.
REQ-016 On each edge, with no flush, entries SHALL shift EX1->EX2->EX3->EX4; the old EX4 entry is discarded.
REQ-017 The new EX1 entry SHALL be {id_valid & id_regwrite & (id_dst!=0) & ~stall, id_dst, id_memread!=0}.
REQ-018 A source SHALL match when it is used, nonzero, and equal to dst of a valid entry.
REQ-019 RAW hazard SHALL assert on a match with a non-load entry in EX1..EX3, or with a load entry in EX1..EX4.
REQ-020 A match with a non-load entry in EX4 SHALL NOT stall, because it is forwarded.
REQ-021 The SAD counter is 2 bits: loaded with 3 when an id_sad instruction issues (id_valid & ~stall & ~flush), decremented when nonzero, otherwise held at 0.
REQ-022 sad_busy SHALL equal (counter != 0).
REQ-023 SAD hazard SHALL assert when id_valid & id_sad & sad_busy.
REQ-024 stall SHALL equal id_valid & (RAW hazard | SAD hazard) & ~flush, combinationally in the same cycle.
REQ-025 flush SHALL equal ex4_redirect, combinationally.
REQ-026 On flush, EX1..EX3 entries SHALL be invalidated at the edge, EX4 SHALL be discarded, no ID instruction is entered, and the SAD counter SHALL be cleared.
REQ-027 Priority: Reset > flush > stall.
REQ-028 stall_count SHALL increment by 1 on each edge where stall=1, and hold at 16'hFFFF.
REQ-029 Register $0 as a source or destination SHALL never cause a hazard.
REQ-030 An instruction that is both a load and a SAD SHALL apply both hazard rules; stall is their OR.

Reset
REQ-031 While Reset=1 at an edge: all entries invalid, dst=0, load=0; SAD counter=0; stall_count=0.
REQ-032 While Reset=1, stall, flush and sad_busy SHALL be driven to 0 regardless of inputs.
REQ-033 Reset asserted mid-stall or mid-SAD SHALL abort the operation; the first cycle after reset behaves as empty pipeline.

Verification
REQ-034 Load to $8 issued, then ID reads $8 -> stall=1 for 4 cycles, 0 on the 5th; stall_count=4.
REQ-035 ALU op writing $9, then ID reads $9 -> stall=1 for 3 cycles; no stall when a 3-instruction gap separates them.
REQ-036 Two back-to-back id_sad -> second stalls 3 cycles; sad_busy high 3 cycles after the first issue.
REQ-037 Load $8 in EX2 plus ex4_redirect=1 with ID reading $8 -> flush=1, stall=0; next cycle scoreboard empty and stall=0.
REQ-038 Force 70000 hazard cycles -> stall_count saturates at 16'hFFFF; Reset -> 0.
REQ-039 ID reads $0 after a write to $0 -> stall=0.
